// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: control codes, operation-field
// encodings and the engine's FSM state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NAND = 4'b1101;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice with optional operand inversion; exposes the
// raw sum so the caller can resolve set-less-than at the MSB.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       less,
   input  logic       a_inv,
   input  logic       b_inv,
   input  logic       cin,
   input  logic [1:0] op,
   output logic       result,
   output logic       sum,
   output logic       cout
);

   logic a_s;
   logic b_s;

   // Invert operands, form full-adder sum/carry and select the result.
   always_comb begin
      a_s  = a ^ a_inv;
      b_s  = b ^ b_inv;
      sum  = a_s ^ b_s ^ cin;
      cout = (a_s & b_s) | (a_s & cin) | (b_s & cin);
      case (op)
         OP_AND:  result = a_s & b_s;
         OP_OR:   result = a_s | b_s;
         OP_ADD:  result = sum;
         OP_LESS: result = less;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_engine.sv
// Bit-serial ALU engine: feeds one alu_bit_slice per clock LSB first, then
// resolves SLT and flags in a fix-up cycle and pulses done_o.
module alu_serial_engine
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ctrl_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
);

   logic [1:0]       state_r;
   logic [CNT_W-1:0] idx_r;
   logic [WIDTH-1:0] src1_r;
   logic [WIDTH-1:0] src2_r;
   logic [3:0]       ctrl_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic             msb_cin_r;
   logic             msb_sum_r;
   logic             msb_cout_r;

   logic             slice_res_s;
   logic             slice_sum_s;
   logic             slice_cout_s;
   logic             set_s;
   logic             is_add_s;
   logic [WIDTH-1:0] final_s;

   alu_bit_slice u_slice (
      .a      (src1_r[idx_r]),
      .b      (src2_r[idx_r]),
      .less   (1'b0),
      .a_inv  (ctrl_r[3]),
      .b_inv  (ctrl_r[2]),
      .cin    (carry_r),
      .op     (ctrl_r[1:0]),
      .result (slice_res_s),
      .sum    (slice_sum_s),
      .cout   (slice_cout_s)
   );

   // SLT takes the true sign of the difference: MSB sum corrected by overflow.
   always_comb begin
      set_s    = msb_sum_r ^ (msb_cin_r ^ msb_cout_r);
      is_add_s = (ctrl_r[1:0] == OP_ADD);
      if (ctrl_r[1:0] == OP_LESS) begin
         final_s = {{(WIDTH-1){1'b0}}, set_s};
      end else begin
         final_s = res_r;
      end
   end

   // Sequencer: IDLE latches, RUN walks the bits, FIX publishes, DONE pulses.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= {CNT_W{1'b0}};
         src1_r     <= {WIDTH{1'b0}};
         src2_r     <= {WIDTH{1'b0}};
         ctrl_r     <= 4'b0000;
         res_r      <= {WIDTH{1'b0}};
         carry_r    <= 1'b0;
         msb_cin_r  <= 1'b0;
         msb_sum_r  <= 1'b0;
         msb_cout_r <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         result_o   <= {WIDTH{1'b0}};
         zero_o     <= 1'b0;
         cout_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  src1_r  <= src1_i;
                  src2_r  <= src2_i;
                  ctrl_r  <= ctrl_i;
                  idx_r   <= {CNT_W{1'b0}};
                  carry_r <= ctrl_i[2];
                  res_r   <= {WIDTH{1'b0}};
                  busy_o  <= 1'b1;
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               res_r[idx_r] <= slice_res_s;
               carry_r      <= slice_cout_s;
               if (idx_r == CNT_W'(WIDTH - 1)) begin
                  msb_cin_r  <= carry_r;
                  msb_sum_r  <= slice_sum_s;
                  msb_cout_r <= slice_cout_s;
                  state_r    <= ST_FIX;
               end else begin
                  idx_r <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_FIX: begin
               result_o   <= final_s;
               zero_o     <= (final_s == {WIDTH{1'b0}});
               cout_o     <= is_add_s & msb_cout_r;
               overflow_o <= is_add_s & (msb_cin_r ^ msb_cout_r);
               done_o     <= 1'b1;
               state_r    <= ST_DONE;
            end
            ST_DONE: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_engine.sv
// Directed table-driven bench for alu_serial_engine plus hand-written
// sequences for start-while-busy, mid-run reset and back-to-back requests.
module tb_alu_serial_engine;
   import alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int NVEC  = 14;

   logic             clk_i = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_i = 1'b0;
   logic [WIDTH-1:0] src1_i = '0;
   logic [WIDTH-1:0] src2_i = '0;
   logic [3:0]       ctrl_i = 4'b0000;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             cout_o;
   logic             overflow_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs [NVEC];

   alu_serial_engine #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .ctrl_i     (ctrl_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .zero_o     (zero_o),
      .cout_o     (cout_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op from IDLE; lat counts posedges from the accepting edge (=1) to done_o seen.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk_i);
      ctrl_i = c; src1_i = a; src2_i = b; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 1;
      check("busy_after_accept", {31'd0, busy_o}, 32'd1);
      while (!done_o && lat < 200) begin
         @(posedge clk_i); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int dones;
      int t1;
      int t2;
      logic [31:0] held;

      vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{ALU_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F00, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{ALU_NAND, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F0FFFF, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{ALU_SLT,  32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{ALU_SLT,  32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{4'b1010,  32'h00000005, 32'h0000000A, 32'h00000004, 1'b0, 1'b1, 1'b0};

      // Reset state
      #12;
      check("rst_busy",   {31'd0, busy_o},     32'd0);
      check("rst_done",   {31'd0, done_o},     32'd0);
      check("rst_result", result_o,            32'd0);
      check("rst_zero",   {31'd0, zero_o},     32'd0);
      check("rst_cout",   {31'd0, cout_o},     32'd0);
      check("rst_ovf",    {31'd0, overflow_o}, 32'd0);
      @(negedge clk_i);
      rst_n = 1'b1;
      repeat (2) @(posedge clk_i);

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), lat, WIDTH + 2);
         check($sformatf("v%0d_result", i), result_o, vecs[i].res);
         check($sformatf("v%0d_zero", i), {31'd0, zero_o}, {31'd0, vecs[i].zero});
         check($sformatf("v%0d_cout", i), {31'd0, cout_o}, {31'd0, vecs[i].cout});
         check($sformatf("v%0d_ovf", i), {31'd0, overflow_o}, {31'd0, vecs[i].ovf});
         @(posedge clk_i); #1;
         check($sformatf("v%0d_done_fell", i), {31'd0, done_o}, 32'd0);
         check($sformatf("v%0d_busy_fell", i), {31'd0, busy_o}, 32'd0);
         check($sformatf("v%0d_result_held", i), result_o, vecs[i].res);
      end

      // start_i pulsed mid-RUN with new operands is ignored
      @(negedge clk_i);
      ctrl_i = ALU_ADD; src1_i = 32'd1; src2_i = 32'd2; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      dones = 0;
      held = 32'hDEADBEEF;
      for (int c = 0; c < 60; c++) begin
         if (c == 5) begin
            src1_i = 32'd100; src2_i = 32'd200; ctrl_i = ALU_OR; start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk_i); #1;
         if (done_o) begin
            dones++;
            held = result_o;
         end
      end
      check("busy_ignore_dones", dones, 32'd1);
      check("busy_ignore_result", held, 32'd3);

      // Reset mid-RUN aborts with no done pulse
      @(negedge clk_i);
      ctrl_i = ALU_ADD; src1_i = 32'd10; src2_i = 32'd20; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",   {31'd0, busy_o},     32'd0);
      check("midrst_done",   {31'd0, done_o},     32'd0);
      check("midrst_result", result_o,            32'd0);
      check("midrst_zero",   {31'd0, zero_o},     32'd0);
      check("midrst_cout",   {31'd0, cout_o},     32'd0);
      check("midrst_ovf",    {31'd0, overflow_o}, 32'd0);
      @(negedge clk_i);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk_i); #1;
         if (done_o) dones++;
      end
      check("midrst_no_done", dones, 32'd0);
      run_op(ALU_ADD, 32'd3, 32'd4, lat);
      check("after_rst_latency", lat, WIDTH + 2);
      check("after_rst_result", result_o, 32'd7);
      @(posedge clk_i); #1;

      // start_i held high: back-to-back ops spaced WIDTH+3 cycles
      @(negedge clk_i);
      ctrl_i = ALU_ADD; src1_i = 32'd1; src2_i = 32'd1; start_i = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int c = 0; c < 90; c++) begin
         @(posedge clk_i); #1;
         if (done_o) begin
            if (t1 < 0) t1 = c;
            else if (t2 < 0) t2 = c;
         end
      end
      start_i = 1'b0;
      check("b2b_spacing", t2 - t1, WIDTH + 3);
      check("b2b_result", result_o, 32'd2);
      repeat (40) @(posedge clk_i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
